alu_operand_sequencer: RTL and testbench

- Upstream input stage for the 4-bit board ALU.
- Converts raw board switches and push-buttons into stable, registered operands and an opcode.
- Debounces two buttons and steps a 4-state entry FSM: operand A, then operand B, then opcode, then hold.
- Outputs drive the ALU's 4-bit operand inputs and 3-bit operation select directly. `valid` tells the display stage when the ALU result is meaningful.

---
 rtl/alu_operand_sequencer.sv | 170 +++++++++++++++++
 tb/tb_alu_operand_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_sequencer.sv
// Board input stage for the 4-bit ALU: synchronizes switches, debounces the step/clear buttons,
// and walks an entry FSM (A -> B -> opcode -> run) that latches the ALU operands and opcode.

module alu_operand_debounce #(
  parameter int CYCLES = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam int CNT_W = $clog2(CYCLES + 1);

  logic             sync_meta;
  logic             sync_lvl;
  logic [CNT_W-1:0] cnt;
  logic             level_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync_lvl  <= 1'b0;
    end else begin
      sync_meta <= raw;
      sync_lvl  <= sync_meta;
    end
  end

  // The counter only runs while the synchronized level disagrees with the accepted level,
  // so any bounce back to the accepted level restarts the qualification window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync_lvl != level) begin
      if (cnt == CNT_W'(CYCLES - 1)) begin
        level <= sync_lvl;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level;
    end
  end

  // Press edge only; built from registers so it is one cycle wide and never repeats while held.
  assign rise = level & ~level_q;

endmodule

module alu_operand_sequencer #(
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  input  logic       btn_next,
  input  logic       btn_clr,
  output logic [3:0] opa,
  output logic [3:0] opb,
  output logic [2:0] opsel,
  output logic       valid,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_A   = 2'b00,
    S_B   = 2'b01,
    S_OP  = 2'b10,
    S_RUN = 2'b11
  } state_t;

  state_t     st;
  logic [3:0] sw_meta;
  logic [3:0] sw_sync;
  logic       next_level;
  logic       next_pulse;
  logic       clr_level;
  logic       clr_pulse;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_meta <= 4'd0;
      sw_sync <= 4'd0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
    end
  end

  alu_operand_debounce #(
    .CYCLES(DEBOUNCE_CYCLES)
  ) u_next_db (
    .clk  (clk),
    .rst  (rst),
    .raw  (btn_next),
    .level(next_level),
    .rise (next_pulse)
  );

  alu_operand_debounce #(
    .CYCLES(DEBOUNCE_CYCLES)
  ) u_clr_db (
    .clk  (clk),
    .rst  (rst),
    .raw  (btn_clr),
    .level(clr_level),
    .rise (clr_pulse)
  );

  // valid is a level, not a handshake: it is high exactly while st==S_RUN and the display
  // stage may sample the ALU result any cycle it is high; there is no ready/back-pressure.
  // Clear outranks step, so a simultaneous step pulse is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st    <= S_A;
      opa   <= 4'd0;
      opb   <= 4'd0;
      opsel <= 3'd0;
      valid <= 1'b0;
    end else if (clr_pulse) begin
      st    <= S_A;
      opa   <= 4'd0;
      opb   <= 4'd0;
      opsel <= 3'd0;
      valid <= 1'b0;
    end else if (next_pulse) begin
      case (st)
        S_A: begin
          opa <= sw_sync;
          st  <= S_B;
        end
        S_B: begin
          opb <= sw_sync;
          st  <= S_OP;
        end
        S_OP: begin
          opsel <= sw_sync[2:0];
          valid <= 1'b1;
          st    <= S_RUN;
        end
        S_RUN: begin
          valid <= 1'b0;
          st    <= S_A;
        end
        default: begin
          valid <= 1'b0;
          st    <= S_A;
        end
      endcase
    end
  end

  assign state = st;

  // Debounced levels are only consumed through their edge pulses.
  logic unused_levels;
  assign unused_levels = next_level ^ clr_level;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Self-checking bench for alu_operand_sequencer: directed entry/bounce/clear/reset scenarios
// plus randomized presses checked against a press-level reference model.

module tb_alu_operand_sequencer;

  localparam int DEB = 4;

  logic       clk;
  logic       rst;
  logic [3:0] sw;
  logic       btn_next;
  logic       btn_clr;
  logic [3:0] opa;
  logic [3:0] opb;
  logic [2:0] opsel;
  logic       valid;
  logic [1:0] state;

  int checks;
  int failures;

  // Reference model: one entry slot per step, advanced only by accepted presses.
  int         m_step;
  logic [3:0] m_a;
  logic [3:0] m_b;
  logic [2:0] m_op;

  logic [13:0] obs;
  assign obs = {opa, opb, opsel, valid, state};

  alu_operand_sequencer #(
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sw      (sw),
    .btn_next(btn_next),
    .btn_clr (btn_clr),
    .opa     (opa),
    .opb     (opb),
    .opsel   (opsel),
    .valid   (valid),
    .state   (state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  task automatic model_clear();
    m_step = 0;
    m_a    = 4'd0;
    m_b    = 4'd0;
    m_op   = 3'd0;
  endtask

  task automatic model_next(input logic [3:0] v);
    if (m_step == 0) m_a = v;
    else if (m_step == 1) m_b = v;
    else if (m_step == 2) m_op = v[2:0];
    m_step = (m_step + 1) % 4;
  endtask

  function automatic logic [13:0] model_vec();
    logic [1:0] s;
    s = m_step[1:0];
    return {m_a, m_b, m_op, (m_step == 3), s};
  endfunction

  // ---------------- drivers ----------------
  task automatic press(input logic use_next, input logic use_clr, input logic [3:0] swv,
                       input int hi, input int lo, input bit scramble);
    sw       = swv;
    btn_next = use_next;
    btn_clr  = use_clr;
    repeat (hi) tick();
    btn_next = 1'b0;
    btn_clr  = 1'b0;
    for (int j = 0; j < lo; j++) begin
      if (scramble && j == lo - 1) sw = 4'($urandom);
      tick();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; sw = 4'h0; btn_next = 1'b0; btn_clr = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++;
    if (obs !== 14'd0) begin
      failures++;
      $display("FAIL reset got=%h want=%h", obs, 14'd0);
    end
  endtask

  task automatic test_full_sequence();
    press(1'b1, 1'b0, 4'h5, 8, 8, 1'b0);
    checks++;
    if (obs !== {4'h5, 4'h0, 3'd0, 1'b0, 2'b01}) begin
      failures++;
      $display("FAIL seq_opa got=%h want=%h", obs, {4'h5, 4'h0, 3'd0, 1'b0, 2'b01});
    end
    press(1'b1, 1'b0, 4'h3, 8, 8, 1'b0);
    checks++;
    if (obs !== {4'h5, 4'h3, 3'd0, 1'b0, 2'b10}) begin
      failures++;
      $display("FAIL seq_opb got=%h want=%h", obs, {4'h5, 4'h3, 3'd0, 1'b0, 2'b10});
    end
    sw = 4'b0001;
    btn_next = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (valid !== (k >= 7)) begin
        failures++;
        $display("FAIL valid_latency edge=%0d got=%b want=%b", k, valid, (k >= 7));
      end
    end
    btn_next = 1'b0;
    repeat (8) tick();
    checks++;
    if (obs !== {4'h5, 4'h3, 3'b001, 1'b1, 2'b11}) begin
      failures++;
      $display("FAIL seq_run got=%h want=%h", obs, {4'h5, 4'h3, 3'b001, 1'b1, 2'b11});
    end
  endtask

  task automatic test_wrap_retain();
    press(1'b1, 1'b0, 4'hE, 8, 8, 1'b0);
    checks++;
    if (obs !== {4'h5, 4'h3, 3'b001, 1'b0, 2'b00}) begin
      failures++;
      $display("FAIL wrap_retain got=%h want=%h", obs, {4'h5, 4'h3, 3'b001, 1'b0, 2'b00});
    end
  endtask

  task automatic test_bounce();
    logic [9:0] pat;
    pat = 10'b1100110011;
    sw = 4'hA;
    for (int i = 9; i >= 0; i--) begin
      btn_next = pat[i];
      tick();
    end
    btn_next = 1'b0;
    repeat (10) tick();
    checks++;
    if (obs !== {4'h5, 4'h3, 3'b001, 1'b0, 2'b00}) begin
      failures++;
      $display("FAIL bounce_reject got=%h want=%h", obs, {4'h5, 4'h3, 3'b001, 1'b0, 2'b00});
    end
    press(1'b1, 1'b0, 4'hA, 6, 10, 1'b0);
    checks++;
    if (obs !== {4'hA, 4'h3, 3'b001, 1'b0, 2'b01}) begin
      failures++;
      $display("FAIL bounce_hold_step got=%h want=%h", obs, {4'hA, 4'h3, 3'b001, 1'b0, 2'b01});
    end
  endtask

  task automatic test_clear_priority();
    press(1'b0, 1'b1, 4'hF, 8, 8, 1'b0);
    checks++;
    if (obs !== 14'd0) begin
      failures++;
      $display("FAIL clear_only got=%h want=%h", obs, 14'd0);
    end
    press(1'b1, 1'b0, 4'h9, 8, 8, 1'b0);
    press(1'b1, 1'b0, 4'h2, 8, 8, 1'b0);
    checks++;
    if (obs !== {4'h9, 4'h2, 3'd0, 1'b0, 2'b10}) begin
      failures++;
      $display("FAIL clear_setup got=%h want=%h", obs, {4'h9, 4'h2, 3'd0, 1'b0, 2'b10});
    end
    press(1'b1, 1'b1, 4'h6, 8, 8, 1'b0);
    checks++;
    if (obs !== 14'd0) begin
      failures++;
      $display("FAIL clear_priority got=%h want=%h", obs, 14'd0);
    end
  endtask

  task automatic test_async_reset();
    press(1'b1, 1'b0, 4'hC, 8, 8, 1'b0);
    sw = 4'h7;
    btn_next = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== 14'd0) begin
      failures++;
      $display("FAIL async_reset_immediate got=%h want=%h", obs, 14'd0);
    end
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      checks++;
      if (state !== ((k >= 7) ? 2'b01 : 2'b00)) begin
        failures++;
        $display("FAIL async_reset_repress edge=%0d got=%b want=%b", k, state,
                 ((k >= 7) ? 2'b01 : 2'b00));
      end
    end
    repeat (10) tick();
    btn_next = 1'b0;
    repeat (10) tick();
    checks++;
    if (obs !== {4'h7, 4'h0, 3'd0, 1'b0, 2'b01}) begin
      failures++;
      $display("FAIL async_reset_single got=%h want=%h", obs, {4'h7, 4'h0, 3'd0, 1'b0, 2'b01});
    end
  endtask

  task automatic test_random();
    int kind;
    int hi;
    int lo;
    logic [3:0] v;
    press(1'b0, 1'b1, 4'h0, DEB + 2, DEB + 4, 1'b0);
    model_clear();
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      hi   = $urandom_range(1, 3 * DEB);
      lo   = $urandom_range(DEB + 3, 2 * DEB + 3);
      v    = 4'($urandom);
      // A press counts only if the level persists for the full debounce window.
      if (kind == 0) begin
        press(1'b0, 1'b1, v, hi, lo, 1'b1);
        if (hi >= DEB) model_clear();
      end else if (kind == 1) begin
        press(1'b1, 1'b1, v, hi, lo, 1'b1);
        if (hi >= DEB) model_clear();
      end else begin
        press(1'b1, 1'b0, v, hi, lo, 1'b1);
        if (hi >= DEB) model_next(v);
      end
      checks++;
      if (obs !== model_vec()) begin
        failures++;
        $display("FAIL random_%0d kind=%0d hi=%0d got=%h want=%h", n, kind, hi, obs, model_vec());
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    checks   = 0;
    failures = 0;
    model_clear();
    test_reset();
    test_full_sequence();
    test_wrap_retain();
    test_bounce();
    test_clear_priority();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
